des_f_pipe: RTL and testbench

//  Two-stage pipelined DES round function f(R,K) with valid/ready flow control.

---
 rtl/des_f_pipe.sv | 156 +++++++++++++++
 tb/tb_des_f_pipe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/des_f_pipe.sv
// rtl/des_f_pipe.sv - two-stage pipelined DES round function f(R,K)
// Stage 1: E expansion xor subkey; stage 2: S-boxes and P permutation.
module des_f_pipe #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      r_in,
  input  logic [47:0]      subkey,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      f_out,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  // Tables hold 1-based DES bit numbers, MSB first.
  localparam int E_TAB [0:47] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1
  };

  localparam int P_TAB [0:31] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  // Indexed by {row, col} = {in[5], in[0], in[4:1]}.
  localparam int SBOX [0:7][0:63] = '{
    '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
       0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
       4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
      15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
    '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
       3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
       0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
      13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
    '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
      13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
      13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
       1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
    '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
      13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
      10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
       3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
    '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
      14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
       4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
      11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
    '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
      10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
       9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
       4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
    '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
      13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
       1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
       6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
    '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
       1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
       7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
       2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
  };

  function automatic logic [3:0] sbox_lookup(input int box, input logic [5:0] g);
    return 4'(SBOX[box][{g[5], g[0], g[4:1]}]);
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [47:0]      s1_data_q, s1_data_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      f_q, f_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic [47:0] xk;
  logic [31:0] s_val;
  logic [31:0] f_comb;
  logic        s2_adv;

  always_comb begin
    xk = '0;
    for (int i = 0; i < 48; i++) begin
      xk[47-i] = r_in[32-E_TAB[i]] ^ subkey[47-i];
    end
  end

  always_comb begin
    s_val = '0;
    for (int k = 0; k < 8; k++) begin
      s_val[31-4*k -: 4] = sbox_lookup(k, s1_data_q[47-6*k -: 6]);
    end
  end

  always_comb begin
    f_comb = '0;
    for (int i = 0; i < 32; i++) begin
      f_comb[31-i] = s_val[32-P_TAB[i]];
    end
  end

  // Stage 2 moves whenever its slot is empty or being drained; stage 1 follows it.
  assign s2_adv   = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_tag_d    = s1_tag_q;
    out_valid_d = out_valid_q;
    f_d         = f_q;
    out_tag_d   = out_tag_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        f_d       = f_comb;
        out_tag_d = s1_tag_q;
      end
    end
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = xk;
        s1_tag_d  = in_tag;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_tag_q    <= '0;
      out_valid_q <= 1'b0;
      f_q         <= '0;
      out_tag_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_tag_q    <= s1_tag_d;
      out_valid_q <= out_valid_d;
      f_q         <= f_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign f_out     = f_q;
  assign out_tag   = out_tag_q;
  assign busy      = s1_valid_q || out_valid_q;

endmodule

// File: tb/tb_des_f_pipe.sv
// tb/tb_des_f_pipe.sv - scoreboard bench for des_f_pipe against a DES-numbered f model
module tb_des_f_pipe;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      r_in;
  logic [47:0]      subkey;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      f_out;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  des_f_pipe #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .r_in(r_in), .subkey(subkey), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .f_out(f_out),
    .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int mode  = 0;  // 0: out_ready=1, 1: random, 2: driven by main
  logic [TAG_W+31:0] sb[$];

  int SB [8][4][16] = '{
    '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
      '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
    '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
      '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
    '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
      '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
    '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
      '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
    '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
      '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
    '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
      '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
    '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
      '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
    '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
      '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}
  };
  int PT [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                  2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};

  // Golden f on 1-based DES bit arrays; E is derived from its 4-step/6-wide window rule.
  function automatic logic [31:0] ref_f(input logic [31:0] r, input logic [47:0] k);
    bit rb [1:32];
    bit xb [1:48];
    bit sbits [1:32];
    logic [31:0] res;
    int row, col, v;
    for (int n = 1; n <= 32; n++) rb[n] = r[32-n];
    for (int i = 1; i <= 48; i++)
      xb[i] = rb[((4*((i-1)/6) + (i-1)%6 - 1 + 32) % 32) + 1] ^ k[48-i];
    for (int b = 0; b < 8; b++) begin
      row = 2*xb[6*b+1] + xb[6*b+6];
      col = 8*xb[6*b+2] + 4*xb[6*b+3] + 2*xb[6*b+4] + xb[6*b+5];
      v = SB[b][row][col];
      for (int j = 0; j < 4; j++) sbits[4*b+1+j] = v[3-j];
    end
    res = '0;
    for (int i = 1; i <= 32; i++) res[32-i] = sbits[PT[i-1]];
    return res;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Handshakes decided at negedge: inputs change only at posedge+1.
  logic              prev_stall = 1'b0;
  logic [31:0]       prev_f;
  logic [TAG_W-1:0]  prev_tag;
  logic [TAG_W+31:0] exp_item;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      check("busy_vs_inflight", busy, sb.size() != 0);
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_f", f_out, prev_f);
        check("stall_tag", out_tag, prev_tag);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          exp_item = sb.pop_front();
          check("result_f", f_out, exp_item[31:0]);
          check("result_tag", out_tag, exp_item[TAG_W+31:32]);
        end
      end
      if (in_valid && in_ready) sb.push_back({in_tag, ref_f(r_in, subkey)});
      prev_stall = out_valid && !out_ready;
      prev_f     = f_out;
      prev_tag   = out_tag;
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (mode == 1) out_ready = 1'($urandom % 2);
    else if (mode == 0) out_ready = 1'b1;
  end

  task automatic send(input logic [31:0] r, input logic [47:0] k,
                      input logic [TAG_W-1:0] t, input bit must_ready);
    int w = 0;
    in_valid = 1'b1; r_in = r; subkey = k; in_tag = t;
    @(negedge clk);
    if (must_ready) check("stream_in_ready", in_ready, 1);
    while (!in_ready) begin
      w++;
      if (w > 200) begin
        check("accept_timeout", 0, 1);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_rand(input bit must_ready);
    send($urandom, {16'($urandom), 32'($urandom)}, TAG_W'($urandom), must_ready);
  endtask

  task automatic drain();
    int w = 0;
    in_valid = 1'b0;
    while ((sb.size() != 0 || busy) && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("drain", sb.size() == 0 && !busy, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    bit a;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    r_in = '0; subkey = '0; in_tag = '0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_f_out", f_out, 0);
    check("rst_out_tag", out_tag, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("model_vector", ref_f(32'hF0AAF0AA, 48'h1B02EFFC7072), 32'h234AA9BB);
    send(32'hF0AAF0AA, 48'h1B02EFFC7072, 1, 1'b1);
    in_valid = 1'b0;
    check("vec_xk", dut.s1_data_q, 48'h6117BA866527);
    check("vec_latency_early", out_valid, 0);
    @(posedge clk);
    #1;
    check("vec_out_valid", out_valid, 1);
    check("vec_f_out", f_out, 32'h234AA9BB);
    check("vec_out_tag", out_tag, 1);
    drain();

    for (int i = 0; i < 64; i++) send_rand(1'b1);
    drain();

    mode = 2; out_ready = 1'b0;
    acc = 0;
    in_valid = 1'b1; r_in = $urandom; subkey = {16'($urandom), 32'($urandom)}; in_tag = 3;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      a = in_ready;
      if (a) acc++;
      @(posedge clk);
      #1;
      if (a) begin
        r_in = $urandom; subkey = {16'($urandom), 32'($urandom)}; in_tag = TAG_W'(c + 4);
      end
    end
    check("bp_accepted", acc, 2);
    check("bp_in_ready_low", in_ready, 0);
    in_valid = 1'b0;
    mode = 0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_rand(1'b0);
    drain();

    mode = 1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom % 2 == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send_rand(1'b0);
    end
    in_valid = 1'b0;
    mode = 0; out_ready = 1'b1;
    drain();

    mode = 2; out_ready = 1'b0;
    send_rand(1'b0);
    send_rand(1'b0);
    in_valid = 1'b0;
    check("full_in_ready", in_ready, 0);
    check("full_busy", busy, 1);
    #2 rst = 1'b1;
    sb.delete();
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_busy", busy, 0);
    check("async_in_ready", in_ready, 1);
    check("async_f_out", f_out, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    mode = 0; out_ready = 1'b1;
    send_rand(1'b1);
    drain();

    send(32'h0, 48'h0, '0, 1'b1);
    send(32'hFFFFFFFF, 48'hFFFFFFFFFFFF, '1, 1'b1);
    send(32'h0, 48'hFFFFFFFFFFFF, TAG_W'(5), 1'b1);
    send(32'hFFFFFFFF, 48'h0, TAG_W'(10), 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
